// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and zero multiplies skip the loop.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  localparam logic [2:0] OP_MUL = 3'b000;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                spec_q, spec_d;
  logic [XLEN-1:0]     spec_val_q, spec_val_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode, used only on the launch edge.
  logic            is_div, a_signed, b_signed, s1_neg, s2_neg;
  logic            div0, ovf, mul0, special;
  logic [XLEN-1:0] a_abs, b_abs, special_val;

  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
    s1_neg   = a_signed & rs1[XLEN-1];
    s2_neg   = b_signed & rs2[XLEN-1];
    a_abs    = s1_neg ? -rs1 : rs1;
    b_abs    = s2_neg ? -rs2 : rs2;
    div0     = is_div && (rs2 == '0);
    ovf      = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    mul0     = !is_div && (rs1 == '0 || rs2 == '0);
    special  = div0 | ovf | mul0;
    special_val = '0;
    if (div0)
      special_val = op[1] ? rs1 : '1;
    else if (ovf)
      special_val = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One loop step. The divide subtract is XLEN+1 bits wide because the
  // shifted partial remainder can exceed XLEN bits for large divisors.
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next = {(div_diff[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_diff[XLEN-1:0]),
                acc_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (spec_q)
      fix_val = spec_val_q;
    else if (op_q[2])
      fix_val = op_q[1] ? rem : quo;
    else
      fix_val = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    done_d     = 1'b0;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d       = op;
          b_d        = b_abs;
          acc_d      = {{XLEN{1'b0}}, a_abs};
          neg_d      = s1_neg ^ s2_neg;
          rneg_d     = s1_neg;
          spec_d     = special;
          spec_val_d = special_val;
          cnt_d      = '0;
`ifdef MULDIV_EARLY_OUT_EN
          state_d    = special ? S_FIX : S_CALC;
`else
          state_d    = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1))
            state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fix_val;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // NOTE: datapath registers are always loaded on launch before use, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    b_q        <= b_d;
    acc_q      <= acc_d;
    neg_q      <= neg_d;
    rneg_q     <= rneg_d;
    spec_q     <= spec_d;
    spec_val_q <= spec_val_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; expected values are hand-computed.
// Special-case latency follows MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_muldiv_sequencer;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int FULL_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Drive one start pulse; returns at the falling edge just after the launch edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; rs1 = 32'hA5A5_5A5A; rs2 = 32'h3C3C_C3C3;
  endtask

  // Counts falling edges until done; a timeout is reported as a failure.
  task automatic wait_done(output logic [31:0] res, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = result;
    if (lat >= 100) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
  endtask

  task automatic run_vec(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    bit bok;
    launch(o, a, b);
    wait_done(res, lat, bok);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, res, exp);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL %s busy: dropped before done", name);
    end
  endtask

  task automatic test_reset;
    start = 1'b1; op = MUL; rs1 = 32'd3; rs2 = 32'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mul;
    run_vec("mul_7x-3",      MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
    run_vec("mulhu_ff",      MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
    run_vec("mulh_ff",       MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FULL_LAT);
    run_vec("mulhsu_ff",     MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT);
    run_vec("mul_2p16sq",    MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, FULL_LAT);
    run_vec("mulhu_2p16sq",  MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, FULL_LAT);
    run_vec("mul_zero",      MUL,    32'h1234_5678, 32'h0,         32'h0000_0000, SPEC_LAT);
  endtask

  task automatic test_div;
    run_vec("div_-7/2",      DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, FULL_LAT);
    run_vec("rem_-7/2",      REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, FULL_LAT);
    run_vec("divu_100/7",    DIVU, 32'd100,       32'd7,         32'd14,        FULL_LAT);
    run_vec("remu_100/7",    REMU, 32'd100,       32'd7,         32'd2,         FULL_LAT);
    run_vec("div_7/-2",      DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
    run_vec("rem_7/-2",      REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         FULL_LAT);
    run_vec("divu_big",      DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         FULL_LAT);
    run_vec("remu_big",      REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, FULL_LAT);
  endtask

  task automatic test_special;
    run_vec("div_5/0",       DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT);
    run_vec("remu_5/0",      REMU, 32'd5,         32'd0,         32'd5,         SPEC_LAT);
    run_vec("div_-5/0",      DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, SPEC_LAT);
    run_vec("rem_-5/0",      REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SPEC_LAT);
    run_vec("div_ovf",       DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_vec("rem_ovf",       REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    bit seen_done;
    prev = result;
    launch(DIVU, 32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: busy=%b done=%b expected 0 0", busy, done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || result !== prev) begin
      errors++;
      $display("FAIL flush_quiet: done_seen=%b result=%h expected 0 %h", seen_done, result, prev);
    end
    flush = 1'b1; start = 1'b1; op = MUL; rs1 = 32'd2; rs2 = 32'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_blocks_start: busy=%b expected 0", busy);
    end
    run_vec("after_flush", MUL, 32'd6, 32'd7, 32'd42, FULL_LAT);
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    launch(MUL, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=1 expected 0");
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    bit bok;
    // Start while busy must not disturb the running multiply.
    launch(MUL, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(res, lat, bok);
    checks++;
    if (res !== 32'd15) begin
      errors++;
      $display("FAIL start_while_busy: got %h expected %h", res, 32'd15);
    end
    // Start on the FIX edge is ignored; held one more cycle it is accepted.
    launch(MUL, 32'd11, 32'd13);
    repeat (32) @(negedge clk);
    start = 1'b1; op = MUL; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd143) begin
      errors++;
      $display("FAIL start_on_done: done=%b busy=%b result=%h expected 1 0 %h", done, busy, result, 32'd143);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_done: busy=%b expected 1", busy);
    end
    wait_done(res, lat, bok);
    checks++;
    if (res !== 32'd4 || lat !== FULL_LAT) begin
      errors++;
      $display("FAIL start_after_done_result: got %h lat %0d expected %h lat %0d", res, lat, 32'd4, FULL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
- Accepts one MUL/DIV-class operation per start pulse and runs a radix-2 shift-add / restoring-divide loop over an internal XLEN-bit adder.
- Holds the pipeline via busy and returns a registered result with a one-cycle done pulse.
- Applies RISC-V sign and special-case rules.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  launch request; sampled only in IDLE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A / dividend
- rs2  input  XLEN  operand B / divisor
- flush  input  1  abort the current operation (branch mispredict / trap)
- busy  output  1  high while the operation is not in IDLE; EX stage stalls on busy
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result; holds its value until the next done

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0. Reset overrides start and flush. Reset mid-operation discards the operation; no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - If start=1 at edge N, latch op, abs/sign-adjusted operands, and the sign flags. Set counter=0 and go to CALC.
  - busy=1 from edge N onward.
  - If start=0, stay in IDLE.
- Signedness rules:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low product bits are sign-agnostic; computed unsigned.
- CALC:
  - One iteration per cycle; counter increments each cycle.
  - After XLEN iterations (edges N+1..N+32 for XLEN=32), go to FIX.
  - Multiply: 2*XLEN product register.
  - Divide: restoring divide, XLEN-bit remainder plus XLEN-bit quotient.
- FIX (edge N+33):
  - Negate product/quotient/remainder as required.
  - Select the low or high product half.
  - Write result, done=1 for exactly that cycle, busy=0, go to IDLE.
- Total latency: start at edge N -> done high in the cycle after edge N+33.
- Result sign rules:
  - Quotient is negated when the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Division by zero:
  - DIV/DIVU quotient = all-ones.
  - REM/REMU = rs1 unchanged.
  - Same latency as normal division.
- Signed overflow (DIV, rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start while busy=1: ignored, with no effect on the current operation. The issuing stage must hold the instruction while stalled.
- start on the same edge done pulses (state IDLE at that edge is false, FIX is active): ignored. A new start is accepted from the next cycle.
- flush=1 at any edge in CALC or FIX: go to IDLE and set busy=0. done stays 0 and result is not updated.
- flush in IDLE: no effect, and it also blocks a simultaneous start (flush wins).
- Operands are latched at start; changes to rs1/rs2/op during busy are ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, the following complete without entering CALC: done pulses in the cycle after edge N+1, result is written at edge N+1, and busy is high only during the cycle after edge N.
  - Divide by zero.
  - Signed overflow.
  - Any multiply with rs1=0 or rs2=0 (result 0).
- When undefined, every operation takes the full XLEN+2 cycle path and the results are identical.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; done exactly 33 cycles after the start cycle; busy high throughout.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0. With MULDIV_EARLY_OUT_EN, each of these completes with done 1 cycle after start.
- Start DIVU, pulse flush at cycle 10 -> busy=0 next cycle, no done, result unchanged. A new start the following cycle completes normally.
- Start MUL, assert rst_n=0 at cycle 5 -> all outputs 0 at the next edge. A second start during busy (with different operands) is ignored, and the first result is returned unchanged.
